// File: rtl/ioctl_sdr_packer.sv
// Packs hps_io byte downloads into 16-bit SDRAM words and issues them as single writes.
module ioctl_sdr_packer #(
    parameter int unsigned INDEX = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [23:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 24;
    localparam int unsigned DW    = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
    } word_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    // Registered state
    logic             dl_q;
    logic             pend_valid_q, pend_valid_d;
    word_t            pend_q, pend_d;
    word_t            fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             req_q, req_d;
    word_t            sdr_word_q, sdr_word_d;
    logic             wait_q, wait_d;
    logic             busy_q, busy_d;

    // Combinational control
    logic             accept;
    logic             push;
    logic             push_en;
    logic             pop;
    logic             full;
    logic             flush;
    word_t            push_word;
    word_t            lane_word;

    // Accepted byte write and the single-lane word it would start
    always_comb begin
        accept         = ioctl_wr & ioctl_download & (ioctl_index == 8'(INDEX));
        lane_word.addr = ioctl_addr[24:1];
        lane_word.data = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
        lane_word.be   = ioctl_addr[0] ? 2'b10 : 2'b01;
    end

    // Pending-word merge, eviction and end-of-download flush
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        push         = 1'b0;
        push_word    = pend_q;
        flush        = 1'b0;
        if (accept) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_d       = lane_word;
            end else if (pend_q.addr == lane_word.addr) begin
                if (ioctl_addr[0]) begin
                    pend_d.data[15:8] = ioctl_dout;
                end else begin
                    pend_d.data[7:0]  = ioctl_dout;
                end
                pend_d.be = pend_q.be | lane_word.be;
                if (pend_d.be == 2'b11) begin
                    push         = 1'b1;
                    push_word    = pend_d;
                    pend_valid_d = 1'b0;
                end
            end else begin
                push      = 1'b1;
                push_word = pend_q;
                pend_d    = lane_word;
            end
        end else if (dl_q && !ioctl_download && pend_valid_q) begin
            flush        = 1'b1;
            push         = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        push_en  = push & ~full;
        pop      = (state_q == ST_REQ) & sdr_rdy;
        wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop);
    end

    // Issue FSM: latch the FIFO head on entry to REQ, hold it until sdr_rdy
    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        sdr_word_d = sdr_word_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d    = ST_REQ;
                    req_d      = 1'b1;
                    sdr_word_d = fifo_q[rd_ptr_q];
                end
            end
            ST_REQ: begin
                req_d = 1'b1;
                if (sdr_rdy) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Throttle and activity flags, computed from next-state values
    always_comb begin
        wait_d = (count_d >= CNT_W'(DEPTH - 2)) | flush;
        busy_d = pend_valid_d | (count_d != '0) | req_d;
    end

    // Control and datapath registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            sdr_word_q   <= '0;
            wait_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dl_q         <= ioctl_download;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            req_q        <= req_d;
            sdr_word_q   <= sdr_word_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
        end
    end

    // FIFO storage; a push into a full FIFO is dropped
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_en) begin
            fifo_q[wr_ptr_q] <= push_word;
        end
    end

    // Overflow means the HPS ignored ioctl_wait
    push_into_full_a: assert property (@(posedge clk_sys) disable iff (reset) !(push && full));

    assign ioctl_wait = wait_q;
    assign sdr_addr   = sdr_word_q.addr;
    assign sdr_data   = sdr_word_q.data;
    assign sdr_be     = sdr_word_q.be;
    assign sdr_req    = req_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ioctl_sdr_packer.sv
// Randomized + directed bench for ioctl_sdr_packer against a word-level reference model.
module tb_ioctl_sdr_packer;

    localparam int unsigned INDEX = 0;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [23:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [23:0] sdr_addr;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic        sdr_req;
    logic        sdr_rdy = 1'b0;
    logic        busy;

    ioctl_sdr_packer #(.INDEX(INDEX), .DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .sdr_addr(sdr_addr),
        .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy),
        .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word queue + pending word) ----------------
    wr_t  exp_q[$];
    wr_t  m_pend;
    logic m_pv = 1'b0;
    logic m_dl = 1'b0;
    logic m_flushed = 1'b0;

    task automatic model_write(input logic [24:0] a, input logic [7:0] d);
        if (m_pv && m_pend.a != a[24:1]) begin
            exp_q.push_back(m_pend);
            m_pv = 1'b0;
        end
        if (!m_pv) begin
            m_pv   = 1'b1;
            m_pend = '0;
            m_pend.a = a[24:1];
        end
        if (a[0]) m_pend.d[15:8] = d;
        else      m_pend.d[7:0]  = d;
        m_pend.be[a[0]] = 1'b1;
        if (m_pend.be == 2'b11) begin
            exp_q.push_back(m_pend);
            m_pv = 1'b0;
        end
    endtask

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pv = 1'b0;
            m_pend = '0;
            m_dl = 1'b0;
            m_flushed = 1'b0;
        end else begin
            m_flushed = 1'b0;
            if (sdr_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ioctl_wr && ioctl_download && ioctl_index == 8'(INDEX)) begin
                model_write(ioctl_addr, ioctl_dout);
            end else if (m_dl && !ioctl_download && m_pv) begin
                exp_q.push_back(m_pend);
                m_pv = 1'b0;
                m_flushed = 1'b1;
            end
            m_dl = ioctl_download;
        end
    end

    // ---------------- per-cycle compare ----------------
    int low_run = 0;
    int wait_hi_cnt = 0;

    always @(negedge clk_sys) begin
        if (reset) begin
            low_run = 0;
        end else begin
            logic [15:0] mask;
            check("busy", busy, m_pv || exp_q.size() > 0);
            check("ioctl_wait", ioctl_wait, (exp_q.size() >= int'(DEPTH - 2)) || m_flushed);
            if (ioctl_wait) wait_hi_cnt++;
            if (exp_q.size() == 0) begin
                check("req_with_nothing_queued", sdr_req, 1'b0);
                low_run = 0;
            end else if (sdr_req) begin
                mask = {{8{exp_q[0].be[1]}}, {8{exp_q[0].be[0]}}};
                check("sdr_addr", sdr_addr, exp_q[0].a);
                check("sdr_be", sdr_be, exp_q[0].be);
                check("sdr_data", sdr_data & mask, exp_q[0].d & mask);
                low_run = 0;
            end else begin
                low_run++;
                if (low_run > 1) check("req_latency", sdr_req, 1'b1);
            end
        end
    end

    // ---------------- SDRAM responder ----------------
    wr_t log_q[$];
    bit  fixed_mode = 1'b0;
    int  fixed_delay = 20;
    int  rsp_cnt = 0;
    int  rsp_tgt = 0;
    int  stray_req = 0;
    int  stray_done = 0;

    always begin
        @(posedge clk_sys);
        #1;
        sdr_rdy = 1'b0;
        if (reset) begin
            rsp_cnt = 0;
        end else if (sdr_req) begin
            if (rsp_cnt == 0) rsp_tgt = fixed_mode ? fixed_delay : int'($urandom_range(0, 3));
            if (rsp_cnt >= rsp_tgt) begin
                sdr_rdy = 1'b1;
                log_q.push_back('{a: sdr_addr, d: sdr_data, be: sdr_be});
                rsp_cnt = 0;
            end else begin
                rsp_cnt++;
            end
        end else if (stray_req != stray_done) begin
            sdr_rdy = 1'b1;
            stray_done++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        int g = 0;
        while (ioctl_wait && g < 2000) begin
            step();
            g++;
        end
        check("wait_release", ioctl_wait, 1'b0);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic drain(input int bound);
        int g = 0;
        while (busy && g < bound) begin
            step();
            g++;
        end
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic check_log(input string name, input int idx, input logic [23:0] a,
                             input logic [15:0] d, input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        if (idx >= log_q.size()) begin
            check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
        end else begin
            check({name, "_addr"}, log_q[idx].a, a);
            check({name, "_be"}, log_q[idx].be, be);
            check({name, "_data"}, log_q[idx].d & mask, d & mask);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int g;
        int w0;

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_req", sdr_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wait", ioctl_wait, 1'b0);
        check("rst_addr", sdr_addr, 24'h0);
        check("rst_data", sdr_data, 16'h0);
        check("rst_be", sdr_be, 2'b00);
        reset = 1'b0;
        step();
        ioctl_download = 1'b1;
        ioctl_index = 8'(INDEX);
        step();

        // Two bytes of one word: req two cycles after the completing write
        base = log_q.size();
        wr_byte(25'h000, 8'h11);
        wr_byte(25'h001, 8'h22);
        check("t1_req_n1", sdr_req, 1'b0);
        step();
        check("t1_req_n2", sdr_req, 1'b1);
        drain(200);
        check("t1_count", 64'(log_q.size()), 64'(base + 1));
        check_log("t1", base, 24'h0, 16'h2211, 2'b11);

        // Partial word evicted by a new address, then flushed by download fall
        base = log_q.size();
        wr_byte(25'h005, 8'hAA);
        wr_byte(25'h010, 8'hBB);
        g = 0;
        while ((log_q.size() < base + 1 || sdr_req) && g < 200) begin
            step();
            g++;
        end
        check("t2_first_done", sdr_req, 1'b0);
        check("t2_busy_pending", busy, 1'b1);
        ioctl_download = 1'b0;
        step();
        check("t2_flush_wait", ioctl_wait, 1'b1);
        check("t2_flush_req_n1", sdr_req, 1'b0);
        step();
        check("t2_flush_req_n2", sdr_req, 1'b1);
        drain(200);
        check_log("t2a", base, 24'h2, 16'hAA00, 2'b10);
        check_log("t2b", base + 1, 24'h8, 16'h00BB, 2'b01);
        ioctl_download = 1'b1;
        step();

        // Overwrite of a set lane before merge
        base = log_q.size();
        wr_byte(25'h000, 8'h01);
        wr_byte(25'h000, 8'h02);
        wr_byte(25'h001, 8'h03);
        drain(200);
        check("t3_count", 64'(log_q.size()), 64'(base + 1));
        check_log("t3", base, 24'h0, 16'h0302, 2'b11);

        // Ignored writes: wrong index, then download inactive
        base = log_q.size();
        ioctl_index = 8'd1;
        wr_byte(25'h040, 8'h5A);
        wr_byte(25'h041, 8'h5B);
        ioctl_index = 8'(INDEX);
        ioctl_download = 1'b0;
        step();
        wr_byte(25'h042, 8'h5C);
        wr_byte(25'h043, 8'h5D);
        repeat (4) step();
        check("t4_busy", busy, 1'b0);
        check("t4_req", sdr_req, 1'b0);
        check("t4_count", 64'(log_q.size()), 64'(base));

        // Stray sdr_rdy while idle does nothing
        stray_req++;
        repeat (3) step();
        check("stray_busy", busy, 1'b0);
        check("stray_count", 64'(log_q.size()), 64'(base));

        // 64-byte stream with slow SDRAM: throttling, ordering, pointer wrap
        ioctl_download = 1'b1;
        step();
        fixed_mode = 1'b1;
        fixed_delay = 20;
        base = log_q.size();
        w0 = wait_hi_cnt;
        for (int i = 0; i < 64; i++) wr_byte(25'(i), 8'(i));
        ioctl_download = 1'b0;
        drain(3000);
        fixed_mode = 1'b0;
        check("t5_count", 64'(log_q.size()), 64'(base + 32));
        check("t5_wait_seen", 64'(wait_hi_cnt > w0), 64'(1));
        for (int i = 0; i < 32; i++) check_log("t5", base + i, 24'(i), {8'(2 * i + 1), 8'(2 * i)}, 2'b11);

        // Randomized traffic
        ioctl_download = 1'b1;
        step();
        for (int it = 0; it < 500; it++) begin
            int r;
            logic [24:0] a;
            r = int'($urandom_range(0, 99));
            a = (r % 10 == 0) ? 25'($urandom) : 25'($urandom_range(0, 15));
            if (r < 80) begin
                ioctl_index = (r < 74) ? 8'(INDEX) : 8'd1;
                wr_byte(a, 8'($urandom));
                ioctl_index = 8'(INDEX);
            end else if (r < 88) begin
                ioctl_download = ~ioctl_download;
                step();
            end else begin
                step();
            end
        end
        ioctl_download = 1'b0;
        step();
        drain(1000);
        check("rand_model_empty", 64'(exp_q.size()), 64'(0));

        // Reset while a request is outstanding, then a clean restart
        ioctl_download = 1'b1;
        fixed_mode = 1'b1;
        fixed_delay = 20;
        step();
        wr_byte(25'h020, 8'h77);
        wr_byte(25'h021, 8'h88);
        g = 0;
        while (!sdr_req && g < 20) begin
            step();
            g++;
        end
        check("t6_req_before_reset", sdr_req, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_req", sdr_req, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_wait", ioctl_wait, 1'b0);
        check("t6_addr", sdr_addr, 24'h0);
        check("t6_data", sdr_data, 16'h0);
        check("t6_be", sdr_be, 2'b00);
        step();
        step();
        reset = 1'b0;
        fixed_mode = 1'b0;
        step();
        base = log_q.size();
        wr_byte(25'h000, 8'h5A);
        wr_byte(25'h001, 8'hA5);
        drain(200);
        check("t6_count", 64'(log_q.size()), 64'(base + 1));
        check_log("t6", base, 24'h0, 16'hA55A, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
